// File: rtl/inspection_station_scheduler_pkg.sv
// Shared types and constants for the two-lane inspection station scheduler.
package inspection_station_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        DONE,
        HALT
    } state_e;

    localparam logic LANE0      = 1'b0;
    localparam logic LANE1      = 1'b1;
    localparam logic RES_PASS   = 1'b1;
    localparam logic RES_REJECT = 1'b0;

    function automatic logic [1:0] lane_onehot(input logic lane);
        return (lane == LANE1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/inspection_station_scheduler_rr_arbiter_2.sv
// Combinational two-way round-robin pick; on contention the lane not served last wins.
module rr_arbiter_2
    import inspection_station_scheduler_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic       valid,
    output logic       lane
);

    always_comb begin
        valid = |req;
        case (req)
            2'b10:   lane = LANE1;
            2'b11:   lane = (last_served == LANE0) ? LANE1 : LANE0;
            default: lane = LANE0;
        endcase
    end

endmodule

// File: rtl/inspection_station_scheduler.sv
// Shares one inspection station between two lanes: grant, strobe, await result,
// count outcomes and halt on a reject streak until the operator clears it.
module inspection_station_scheduler
    import inspection_station_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYC    = 15,
    parameter int CNT_W          = 8,
    parameter int MAX_REJ_STREAK = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic             ri_valid,
    input  logic             ri,
    input  logic             clear_alarm,
    output logic [1:0]       grant,
    output logic             p,
    output logic             busy,
    output logic [1:0]       done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] rej_cnt,
    output logic             alarm,
    output logic             timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int STK_W = $clog2(MAX_REJ_STREAK + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_REJ_STREAK);

    state_e           state;
    logic             lane;
    logic             last_served;
    logic [TMR_W-1:0] timer;
    logic [STK_W-1:0] streak;

    logic arb_valid;
    logic arb_lane;
    logic wait_fin;
    logic fin_res;
    logic fin_tmo;

    rr_arbiter_2 u_arb (
        .req         (req),
        .last_served (last_served),
        .valid       (arb_valid),
        .lane        (arb_lane)
    );

    // A result arriving on the last allowed cycle beats the timeout.
    always_comb begin
        wait_fin = 1'b0;
        fin_res  = RES_REJECT;
        fin_tmo  = 1'b0;
        if (state == WAIT) begin
            if (ri_valid) begin
                wait_fin = 1'b1;
                fin_res  = ri;
            end else if (timer == TMR_LAST) begin
                wait_fin = 1'b1;
                fin_tmo  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lane        <= LANE0;
            last_served <= LANE1;
            timer       <= '0;
            streak      <= '0;
            grant       <= '0;
            p           <= 1'b0;
            busy        <= 1'b0;
            done        <= '0;
            pass        <= 1'b0;
            pass_cnt    <= '0;
            rej_cnt     <= '0;
            alarm       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            p    <= 1'b0;
            done <= '0;
            pass <= 1'b0;
            if (clear_alarm)
                timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state <= LOAD;
                        lane  <= arb_lane;
                        grant <= lane_onehot(arb_lane);
                        p     <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= WAIT;
                    timer <= '0;
                end
                WAIT: begin
                    if (wait_fin) begin
                        state <= DONE;
                        done  <= lane_onehot(lane);
                        pass  <= fin_res;
                        if (fin_tmo)
                            timeout_err <= 1'b1;
                        // Counters are updated on entry so they are visible alongside done.
                        if (fin_res == RES_PASS) begin
                            streak <= '0;
                            if (pass_cnt != '1)
                                pass_cnt <= pass_cnt + CNT_W'(1);
                        end else begin
                            if (streak != STK_MAX)
                                streak <= streak + STK_W'(1);
                            if (rej_cnt != '1)
                                rej_cnt <= rej_cnt + CNT_W'(1);
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DONE: begin
                    last_served <= lane;
                    grant       <= '0;
                    busy        <= 1'b0;
                    if (streak == STK_MAX) begin
                        state <= HALT;
                        alarm <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    if (clear_alarm) begin
                        state  <= IDLE;
                        alarm  <= 1'b0;
                        streak <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inspection_station_scheduler.sv
// Directed scenarios plus randomized traffic checked every cycle against a
// service-age model of the scheduler.
module tb_inspection_station_scheduler;

    localparam int TO = 15;
    localparam int CW = 8;
    localparam int MS = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic          ri_valid;
    logic          ri;
    logic          clear_alarm;
    logic [1:0]    grant;
    logic          p;
    logic          busy;
    logic [1:0]    done;
    logic          pass;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] rej_cnt;
    logic          alarm;
    logic          timeout_err;

    inspection_station_scheduler #(
        .TIMEOUT_CYC    (TO),
        .CNT_W          (CW),
        .MAX_REJ_STREAK (MS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ri_valid    (ri_valid),
        .ri          (ri),
        .clear_alarm (clear_alarm),
        .grant       (grant),
        .p           (p),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .pass_cnt    (pass_cnt),
        .rej_cnt     (rej_cnt),
        .alarm       (alarm),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: a service is described by its owner lane and its age in cycles
    // since the grant (age 1 = strobe cycle); done_age marks the result cycle.
    int m_owner, m_age, m_done_age, m_last, m_streak, m_pass_n, m_rej_n;
    bit m_halt, m_res, m_terr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic finish_service(input bit res);
        m_done_age = m_age + 1;
        m_res = res;
        if (res) begin
            m_pass_n = (m_pass_n < 255) ? m_pass_n + 1 : 255;
            m_streak = 0;
        end else begin
            m_rej_n  = (m_rej_n < 255) ? m_rej_n + 1 : 255;
            m_streak = (m_streak < MS) ? m_streak + 1 : MS;
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_owner = -1; m_age = 0; m_done_age = 0; m_last = 1;
            m_streak = 0; m_pass_n = 0; m_rej_n = 0;
            m_halt = 0; m_res = 0; m_terr = 0;
        end else begin
            if (clear_alarm) m_terr = 0;
            if (m_halt) begin
                if (clear_alarm) begin
                    m_halt = 0;
                    m_streak = 0;
                end
            end else if (m_owner < 0) begin
                if (req != 2'b00) begin
                    if (req == 2'b11) m_owner = 1 - m_last;
                    else              m_owner = req[1] ? 1 : 0;
                    m_age = 1;
                    m_done_age = 0;
                end
            end else if (m_done_age != 0 && m_age == m_done_age) begin
                m_last = m_owner;
                m_owner = -1;
                if (m_streak >= MS) m_halt = 1;
            end else begin
                if (m_age >= 2 && m_done_age == 0) begin
                    if (ri_valid) begin
                        finish_service(ri);
                    end else if (m_age - 1 == TO) begin
                        finish_service(1'b0);
                        m_terr = 1;
                    end
                end
                m_age++;
            end
        end
    endtask

    task automatic check_outputs();
        logic [1:0] eg;
        logic       dn;
        eg = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
        dn = (m_owner >= 0) && (m_done_age == m_age);
        chk("grant",       grant,       eg);
        chk("p",           p,           (m_owner >= 0) && (m_age == 1));
        chk("busy",        busy,        m_owner >= 0);
        chk("done",        done,        dn ? eg : 2'b00);
        chk("pass",        pass,        dn && m_res);
        chk("alarm",       alarm,       m_halt);
        chk("timeout_err", timeout_err, m_terr);
        chk("pass_cnt",    pass_cnt,    m_pass_n);
        chk("rej_cnt",     rej_cnt,     m_rej_n);
        chk("grant_onehot0", $onehot0(grant), 1);
    endtask

    task automatic cyc(input logic [1:0] rq, input logic rv, input logic r, input logic clr);
        req = rq; ri_valid = rv; ri = r; clear_alarm = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    logic [1:0] gq[$];

    initial begin
        reset = 1'b1; req = '0; ri_valid = 1'b0; ri = 1'b0; clear_alarm = 1'b0;
        do_reset();

        // Single pass on lane 0 with the fastest possible result.
        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        chk("s1_p", p, 1);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b1, 1'b0);
        chk("s1_done", done, 2'b01);
        chk("s1_pass", pass, 1);
        chk("s1_pass_cnt", pass_cnt, 1);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);

        // Contention alternates lanes; the fifth grant shows lane 1 was served last.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cyc(2'b11, 1'b1, 1'b1, 1'b0);
            if (p) gq.push_back(grant);
        end
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        chk("s2_grants", gq.size(), 5);
        for (int i = 0; i < gq.size(); i++)
            chk("s2_rr", gq[i], (i % 2 == 0) ? 2'b01 : 2'b10);

        // Full timeout, then a result landing on the last allowed cycle.
        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(2'b00, 1'b0, 1'b0, 1'b0);
        chk("s3_terr", timeout_err, 1);
        chk("s3_rej", rej_cnt, 1);
        cyc(2'b00, 1'b0, 1'b0, 1'b1);
        chk("s3_terr_clr", timeout_err, 0);
        cyc(2'b01, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TO - 1; i++) cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b1, 1'b0);
        chk("s3_late_done", done, 2'b01);
        chk("s3_late_pass", pass, 1);
        chk("s3_late_terr", timeout_err, 0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);

        // Reject streak halts; clear resumes and a single reject does not halt.
        for (int i = 0; i < MS; i++) begin
            cyc(2'b11, 1'b0, 1'b0, 1'b0);
            cyc(2'b00, 1'b0, 1'b0, 1'b0);
            cyc(2'b00, 1'b1, 1'b0, 1'b0);
            cyc(2'b00, 1'b0, 1'b0, 1'b0);
        end
        chk("s4_alarm", alarm, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b11, 1'b1, 1'b1, 1'b0);
            chk("s4_halt_grant", grant, 2'b00);
        end
        cyc(2'b00, 1'b0, 1'b0, 1'b1);
        chk("s4_cleared", alarm, 0);
        cyc(2'b11, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b1, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        chk("s4_no_halt", alarm, 0);

        // Pass counter saturation.
        for (int i = 0; i < 256; i++) begin
            cyc(2'b01, 1'b0, 1'b0, 1'b0);
            cyc(2'b00, 1'b0, 1'b0, 1'b0);
            cyc(2'b00, 1'b1, 1'b1, 1'b0);
            cyc(2'b00, 1'b0, 1'b0, 1'b0);
        end
        chk("s5_pass_sat", pass_cnt, 255);
        chk("s5_rej", rej_cnt, 5);

        // Reset in the middle of WAIT.
        cyc(2'b10, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        cyc(2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc(2'b00, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        chk("s6_done", done, 2'b00);
        chk("s6_pass_cnt", pass_cnt, 0);
        chk("s6_grant", grant, 2'b00);
        for (int i = 0; i < 3; i++) cyc(2'b00, 1'b1, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            cyc(2'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
                ($urandom_range(0, 15) == 0));
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
